// File: rtl/norm_sfp.sv
// Normalizes a psum vector by the combined (own + peer) absolute sum, one vector in flight.
// Build option: NORM_PEER_EXCH_EN enables the peer-sum exchange; when undefined only the own sum is used.
module norm_sfp #(
  parameter int bw_psum = 20,
  parameter int col     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*bw_psum-1:0]   in_data,
  output logic [bw_psum+3:0]       sum_out,
  output logic                     sum_out_valid,
  input  logic                     sum_out_ack,
  input  logic [bw_psum+3:0]       sum_in,
  input  logic                     sum_in_valid,
  output logic                     sum_in_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*bw_psum-1:0]   out_data,
  output logic                     err_div0,
  output logic [7:0]               vec_cnt
);

  localparam int SW = bw_psum + 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXCH = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  // |x| as an unsigned lane-width value; the most-negative lane maps to 2^(bw_psum-1).
  function automatic logic [bw_psum-1:0] abs_lane(input logic signed [bw_psum-1:0] x);
    logic [bw_psum-1:0] u;
    u = x;
    if (x[bw_psum-1]) u = ~u + bw_psum'(1);
    return u;
  endfunction

  // Signed lane over unsigned divisor, truncating toward zero; a zero divisor yields 0.
  function automatic logic [bw_psum-1:0] div_lane(input logic signed [bw_psum-1:0] x,
                                                  input logic [bw_psum-1:0] d);
    logic signed [bw_psum:0] n;
    logic signed [bw_psum:0] dd;
    logic signed [bw_psum:0] q;
    n  = {x[bw_psum-1], x};
    dd = {1'b0, d};
    if (d == '0) q = '0;
    else         q = n / dd;
    return q[bw_psum-1:0];
  endfunction

  logic [1:0]             state_q, state_d;
  logic                   ph_q, ph_d;
  logic                   rdy_q;
  logic [SW-1:0]          own_q, own_d;
  logic [col*bw_psum-1:0] data_q, data_d;
  logic [bw_psum-1:0]     div_q, div_d;
  logic [col*bw_psum-1:0] res_q, res_d;
  logic                   err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [SW-1:0]          own_sum;
  logic [bw_psum-1:0]     div_calc;

`ifdef NORM_PEER_EXCH_EN
  logic                   own_done_q, own_done_d;
  logic                   peer_done_q, peer_done_d;
  logic [SW-1:0]          peer_q, peer_d;
  logic                   own_now, peer_now;
`else
  logic                   unused_peer;
  assign unused_peer = ^{sum_out_ack, sum_in_valid, sum_in};
`endif

  always_comb begin
    own_sum = '0;
    for (int k = 0; k < col; k++)
      own_sum = own_sum + SW'(abs_lane(in_data[k*bw_psum +: bw_psum]));
  end

`ifdef NORM_PEER_EXCH_EN
  assign div_calc = bw_psum'(own_q[SW-1:7]) + bw_psum'(peer_q[SW-1:7]);
`else
  assign div_calc = bw_psum'(own_q[SW-1:7]);
`endif

  assign in_ready  = rdy_q && (state_q == S_IDLE);
  assign sum_out   = own_q;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = res_q;
  assign err_div0  = err_q;
  assign vec_cnt   = cnt_q;

`ifdef NORM_PEER_EXCH_EN
  assign sum_out_valid = (state_q == S_EXCH) && !own_done_q;
  assign sum_in_ack    = (state_q == S_EXCH) && sum_in_valid && !peer_done_q;
  assign own_now       = own_done_q || (sum_out_valid && sum_out_ack);
  assign peer_now      = peer_done_q || sum_in_ack;
`else
  assign sum_out_valid = 1'b0;
  assign sum_in_ack    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    own_d   = own_q;
    data_d  = data_q;
    div_d   = div_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef NORM_PEER_EXCH_EN
    own_done_d  = own_done_q;
    peer_done_d = peer_done_q;
    peer_d      = peer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_ready && in_valid) begin
          data_d = in_data;
          own_d  = own_sum;
          ph_d   = 1'b0;
`ifdef NORM_PEER_EXCH_EN
          own_done_d  = 1'b0;
          peer_done_d = 1'b0;
          state_d     = S_EXCH;
`else
          state_d     = S_DIV;
`endif
        end
      end
`ifdef NORM_PEER_EXCH_EN
      S_EXCH: begin
        if (sum_out_valid && sum_out_ack) own_done_d = 1'b1;
        if (sum_in_ack) begin
          peer_d      = sum_in;
          peer_done_d = 1'b1;
        end
        if (own_now && peer_now) state_d = S_DIV;
      end
`endif
      // DIV runs in two steps: register the divisor, then all lane quotients.
      S_DIV: begin
        if (!ph_q) begin
          div_d = div_calc;
          ph_d  = 1'b1;
        end else begin
          for (int k = 0; k < col; k++)
            res_d[k*bw_psum +: bw_psum] = div_lane(data_q[k*bw_psum +: bw_psum], div_q);
          if (div_q == '0) err_d = 1'b1;
          ph_d    = 1'b0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      rdy_q   <= 1'b0;
      own_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef NORM_PEER_EXCH_EN
      own_done_q  <= 1'b0;
      peer_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rdy_q   <= 1'b1;
      own_q   <= own_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef NORM_PEER_EXCH_EN
      own_done_q  <= own_done_d;
      peer_done_q <= peer_done_d;
`endif
    end
  end

  // Pure datapath holding registers; their content is only consumed after a fresh capture.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    div_q  <= div_d;
`ifdef NORM_PEER_EXCH_EN
    peer_q <= peer_d;
`endif
  end

endmodule

// File: tb/tb_norm_sfp.sv
// Self-checking bench for norm_sfp against a plain-arithmetic reference model.
module tb_norm_sfp;
  localparam int BW  = 20;
  localparam int COL = 8;
  localparam int SW  = BW + 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [COL*BW-1:0] in_data;
  logic [SW-1:0]     sum_out;
  logic              sum_out_valid;
  logic              sum_out_ack;
  logic [SW-1:0]     sum_in;
  logic              sum_in_valid;
  logic              sum_in_ack;
  logic              out_valid;
  logic              out_ready;
  logic [COL*BW-1:0] out_data;
  logic              err_div0;
  logic [7:0]        vec_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  bit exp_err = 1'b0;

`ifdef NORM_PEER_EXCH_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  norm_sfp #(.bw_psum(BW), .col(COL)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid), .sum_out_ack(sum_out_ack),
    .sum_in(sum_in), .sum_in_valid(sum_in_valid), .sum_in_ack(sum_in_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_div0(err_div0), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [COL*BW-1:0] model_out(input logic [COL*BW-1:0] v,
                                                  input logic [SW-1:0] peer,
                                                  output int own, output int dv);
    logic [COL*BW-1:0] r;
    int x;
    int q;
    r = '0;
    own = 0;
    for (int k = 0; k < COL; k++) begin
      x = $signed(v[k*BW +: BW]);
      own += (x < 0) ? -x : x;
    end
`ifdef NORM_PEER_EXCH_EN
    dv = ((own >> 7) + (int'(peer) >> 7)) % (1 << BW);
`else
    dv = (own >> 7) % (1 << BW);
`endif
    for (int k = 0; k < COL; k++) begin
      x = $signed(v[k*BW +: BW]);
      q = (dv == 0) ? 0 : x / dv;
      r[k*BW +: BW] = q[BW-1:0];
    end
    return r;
  endfunction

  function automatic logic [COL*BW-1:0] splat(input int val);
    logic [COL*BW-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = val[BW-1:0];
    return r;
  endfunction

  // Drives one vector through the full handshake and reports what it observed.
  task automatic run_vec(input logic [COL*BW-1:0] v, input logic [SW-1:0] peer,
                         input int ack_at, input int peer_at, input int hold,
                         output int lat, output logic [COL*BW-1:0] got, output int pulses,
                         output logic [SW-1:0] so, output bit so_seen,
                         output bit rdy_bad, output bit unstable, output bit tmo);
    int k;
    int w;
    bit peer_done;
    tmo = 0; lat = 0; pulses = 0; so = '0; so_seen = 0;
    rdy_bad = 0; unstable = 0; got = '0; peer_done = 0;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    if (in_ready !== 1'b1) begin tmo = 1; return; end
    in_valid = 1'b1; in_data = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (out_valid !== 1'b1 && k < 60) begin
      if (in_ready !== 1'b0) rdy_bad = 1;
      sum_out_ack  = (k >= ack_at) && (sum_out_valid === 1'b1);
      sum_in_valid = (k >= peer_at) && !peer_done;
      sum_in       = peer;
      #1;
      if (sum_out_valid === 1'b1) begin so = sum_out; so_seen = 1; end
      if (sum_in_ack === 1'b1) begin pulses++; peer_done = 1; end
      @(posedge clk); #1;
      sum_out_ack = 1'b0;
      if (peer_done) sum_in_valid = 1'b0;
      k++;
    end
    sum_in_valid = 1'b0;
    if (out_valid !== 1'b1) begin tmo = 1; return; end
    lat = k - 1;
    got = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (out_data !== got || out_valid !== 1'b1) unstable = 1;
      if (in_ready !== 1'b0) rdy_bad = 1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; sum_out_ack = 1'b0;
    sum_in = 24'h000400; sum_in_valid = 1'b1; out_ready = 1'b0;
    #12;
    checks++;
    if ({in_ready, sum_out_valid, sum_in_ack, out_valid, err_div0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {in_ready, sum_out_valid, sum_in_ack, out_valid, err_div0});
    end
    checks++;
    if (sum_out !== '0 || out_data !== '0 || vec_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: sum_out %0h out_data %0h vec_cnt %0d required all 0",
               sum_out, out_data, vec_cnt);
    end
    sum_in_valid = 1'b0;
    #10 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: got %b required 1", in_ready);
    end
    exp_cnt = 0; exp_err = 1'b0;
  endtask

  task automatic test_basic();
    int lat, pulses, own, dv; logic [COL*BW-1:0] got, exp; logic [SW-1:0] so;
    bit so_seen, rdy_bad, unstable, tmo;
    logic [COL*BW-1:0] v;
    v = splat(128);
    exp = model_out(v, 24'd1024, own, dv);
    run_vec(v, 24'd1024, 1, 1, 0, lat, got, pulses, so, so_seen, rdy_bad, unstable, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL basic_timeout: no out_valid"); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL basic_model: got %h required %h", got, exp); end
    checks++;
`ifdef NORM_PEER_EXCH_EN
    if (got !== splat(8)) begin errors++; $display("FAIL basic_lanes8: got %h required %h", got, splat(8)); end
`else
    if (got !== splat(16)) begin errors++; $display("FAIL basic_lanes16: got %h required %h", got, splat(16)); end
`endif
    checks++;
    if (lat != EXP_LAT) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, EXP_LAT); end
    checks++;
    if (vec_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL basic_vec_cnt: got %0d required %0d", vec_cnt, exp_cnt); end
    checks++;
    if (rdy_bad) begin errors++; $display("FAIL basic_in_ready: got 1 while busy required 0"); end
`ifdef NORM_PEER_EXCH_EN
    checks++;
    if (!so_seen || so !== 24'(own)) begin
      errors++; $display("FAIL basic_sum_out: got %0d seen %0d required %0d", so, so_seen, own);
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL basic_ack_pulses: got %0d required 1", pulses); end
`else
    checks++;
    if (so_seen || pulses != 0) begin
      errors++; $display("FAIL basic_no_exch: sum_out_valid seen %0d ack pulses %0d required 0 0", so_seen, pulses);
    end
`endif
  endtask

  task automatic test_negative();
    int lat, pulses, own, dv; logic [COL*BW-1:0] got, exp, v; logic [SW-1:0] so;
    bit so_seen, rdy_bad, unstable, tmo;
    v = '0; v[BW-1:0] = 20'hFFF00;
    exp = model_out(v, 24'd0, own, dv);
    run_vec(v, 24'd0, 1, 1, 0, lat, got, pulses, so, so_seen, rdy_bad, unstable, tmo);
    checks++;
    if (tmo || got !== exp) begin errors++; $display("FAIL neg_model: got %h required %h tmo %0d", got, exp, tmo); end
    checks++;
    if (got[BW-1:0] !== 20'hFFF80 || got[COL*BW-1:BW] !== '0) begin
      errors++; $display("FAIL neg_lane0: got %h required lane0 fff80 others 0", got);
    end
`ifdef NORM_PEER_EXCH_EN
    checks++;
    if (so !== 24'd256) begin errors++; $display("FAIL neg_sum_out: got %0d required 256", so); end
`endif
  endtask

  task automatic test_div0();
    int lat, pulses, own, dv; logic [COL*BW-1:0] got, exp; logic [SW-1:0] so;
    bit so_seen, rdy_bad, unstable, tmo;
    exp = model_out(splat(10), 24'd0, own, dv);
    run_vec(splat(10), 24'd0, 1, 1, 0, lat, got, pulses, so, so_seen, rdy_bad, unstable, tmo);
    if (dv == 0) exp_err = 1'b1;
    checks++;
    if (tmo || got !== '0) begin errors++; $display("FAIL div0_data: got %h required 0 tmo %0d", got, tmo); end
    checks++;
    if (err_div0 !== 1'b1) begin errors++; $display("FAIL div0_flag: got %b required 1", err_div0); end
    exp = model_out(splat(128), 24'd1024, own, dv);
    run_vec(splat(128), 24'd1024, 1, 1, 0, lat, got, pulses, so, so_seen, rdy_bad, unstable, tmo);
    checks++;
    if (tmo || got !== exp) begin errors++; $display("FAIL div0_next_data: got %h required %h", got, exp); end
    checks++;
    if (err_div0 !== 1'b1) begin errors++; $display("FAIL div0_sticky: got %b required 1", err_div0); end
  endtask

  task automatic test_stall();
    int lat, pulses, own, dv; logic [COL*BW-1:0] got, exp, v; logic [SW-1:0] so;
    bit so_seen, rdy_bad, unstable, tmo;
    for (int k = 0; k < COL; k++) v[k*BW +: BW] = BW'(k * 4000 - 13000);
    exp = model_out(v, 24'd5000, own, dv);
    run_vec(v, 24'd5000, 1, 5, 5, lat, got, pulses, so, so_seen, rdy_bad, unstable, tmo);
    checks++;
    if (tmo || got !== exp) begin errors++; $display("FAIL stall_data: got %h required %h tmo %0d", got, exp, tmo); end
    checks++;
    if (unstable) begin errors++; $display("FAIL stall_stable: out_data changed while out_ready low, required stable"); end
    checks++;
    if (rdy_bad) begin errors++; $display("FAIL stall_in_ready: got 1 while busy required 0"); end
    checks++;
    if (vec_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL stall_vec_cnt: got %0d required %0d", vec_cnt, exp_cnt); end
`ifdef NORM_PEER_EXCH_EN
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL stall_ack_pulse: got %0d pulses required 1", pulses); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, pulses, own, dv; logic [COL*BW-1:0] got, exp; logic [SW-1:0] so;
    bit so_seen, rdy_bad, unstable, tmo;
    in_valid = 1'b1; in_data = splat(300);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, sum_out_valid, sum_in_ack, out_valid, err_div0} !== 5'b0 ||
        sum_out !== '0 || out_data !== '0 || vec_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs: ctrl %b sum_out %0h out_data %0h vec_cnt %0d required all 0",
               {in_ready, sum_out_valid, sum_in_ack, out_valid, err_div0}, sum_out, out_data, vec_cnt);
    end
    @(posedge clk); #3 reset = 1'b1;
    exp_cnt = 0; exp_err = 1'b0;
    exp = model_out(splat(128), 24'd1024, own, dv);
    run_vec(splat(128), 24'd1024, 1, 1, 0, lat, got, pulses, so, so_seen, rdy_bad, unstable, tmo);
    checks++;
    if (tmo || got !== exp || lat != EXP_LAT) begin
      errors++; $display("FAIL midreset_next: got %h lat %0d required %h lat %0d", got, lat, exp, EXP_LAT);
    end
    checks++;
    if (vec_cnt !== 8'd1) begin errors++; $display("FAIL midreset_vec_cnt: got %0d required 1", vec_cnt); end
  endtask

  task automatic test_random();
    int lat, pulses, own, dv, sel; logic [COL*BW-1:0] got, exp, v; logic [SW-1:0] so, peer;
    bit so_seen, rdy_bad, unstable, tmo, tiny;
    for (int n = 0; n < 270; n++) begin
      tiny = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < COL; k++) begin
        sel = $urandom_range(0, 7);
        if (tiny)          v[k*BW +: BW] = BW'($urandom_range(0, 15));
        else if (sel == 0) v[k*BW +: BW] = 20'h80000;
        else if (sel == 1) v[k*BW +: BW] = 20'h7FFFF;
        else               v[k*BW +: BW] = BW'($urandom);
      end
      peer = tiny ? SW'($urandom_range(0, 127)) : SW'($urandom_range(0, 1 << 16));
      exp = model_out(v, peer, own, dv);
      if (dv == 0) exp_err = 1'b1;
      run_vec(v, peer, $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2),
              lat, got, pulses, so, so_seen, rdy_bad, unstable, tmo);
      checks++;
      if (tmo || got !== exp) begin
        errors++; $display("FAIL rand_data[%0d]: got %h required %h tmo %0d", n, got, exp, tmo);
      end
      checks++;
      if (vec_cnt !== 8'(exp_cnt) || err_div0 !== exp_err) begin
        errors++; $display("FAIL rand_status[%0d]: vec_cnt %0d err %b required %0d %b",
                           n, vec_cnt, err_div0, exp_cnt, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_div0();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
